// File: rtl/serial_sub_ctrl_pkg.sv
// Shared ALU definitions for the bit-serial subtractor: state encodings,
// the FSM state type and the default operand width.
package serial_sub_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Encoding 2'd3 is unused; the FSM recovers from it to IDLE on the next edge.
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// One-bit full subtractor built from gate primitives:
// d = x ^ y ^ bin, bout = (~x & y) | (~(x ^ y) & bin).
module sub_bit_cell (
    output logic bout,
    output logic d,
    input  logic x,
    input  logic y,
    input  logic bin
);

    logic x_xor_y;
    logic x_n;
    logic x_xnor_y;
    logic term_a;
    logic term_b;

    xor g_xy   (x_xor_y, x, y);
    xor g_d    (d, x_xor_y, bin);
    not g_xn   (x_n, x);
    not g_xnor (x_xnor_y, x_xor_y);
    and g_ta   (term_a, x_n, y);
    and g_tb   (term_b, x_xnor_y, bin);
    or  g_bout (bout, term_a, term_b);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: shifts one operand bit pair per cycle, LSB
// first, through a single sub_bit_cell with a registered borrow chain.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bflop_q, bflop_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   diff_q, diff_d;

    logic cell_d;
    logic cell_bout;

    sub_bit_cell u_cell (
        .bout (cell_bout),
        .d    (cell_d),
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (bflop_q)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        bflop_d = bflop_q;
        diff_d  = diff_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = b;
                    bflop_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                res_d   = {cell_d, res_q[WIDTH-1:1]};
                bflop_d = cell_bout;
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                // The final bit goes straight into diff so it is valid with done.
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    diff_d  = {cell_bout, cell_d, res_q[WIDTH-1:1]};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bflop_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bflop_q <= bflop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = diff_q[WIDTH];

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and swept checks of serial_sub_ctrl at WIDTH = 4 and WIDTH = 8.
module tb_serial_sub_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] a, b;
    logic       busy, done, borrow;
    logic [4:0] diff;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, borrow8;
    logic [8:0] diff8;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clock  (clock),
        .reset  (reset),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Pulse start for one edge, scramble the inputs afterwards, and check
    // busy/done on every cycle plus the result exactly WIDTH edges later.
    task automatic run4(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                        input logic [4:0] exp_diff);
        start = 1'b1;
        a     = ai;
        b     = bi;
        tick();
        start = 1'b0;
        a     = ~ai;
        b     = ~bi;
        check({tag, " busy@E0"}, 16'(busy), 16'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k < 4) begin
                check({tag, " early_done"}, 16'(done), 16'd0);
            end else begin
                check({tag, " done"},   16'(done),   16'd1);
                check({tag, " diff"},   16'(diff),   16'(exp_diff));
                check({tag, " borrow"}, 16'(borrow), 16'(exp_diff[4]));
            end
        end
        tick();
        check({tag, " idle_busy"}, 16'(busy), 16'd0);
        check({tag, " idle_done"}, 16'(done), 16'd0);
        $display("[TB] W4 a=%b b=%b diff=%b borrow=%b", ai, bi, diff, borrow);
    endtask

    task automatic run8(input logic [7:0] ai, input logic [7:0] bi);
        logic [8:0] exp_diff;
        int lat;
        exp_diff = {1'b0, ai} - {1'b0, bi};
        start8 = 1'b1;
        a8     = ai;
        b8     = bi;
        tick();
        start8 = 1'b0;
        a8     = ~ai;
        lat    = 0;
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
        check("w8 latency", 16'(lat),     16'd8);
        check("w8 diff",    16'(diff8),   16'(exp_diff));
        check("w8 borrow",  16'(borrow8), 16'(exp_diff[8]));
        tick();
        $display("[TB] W8 a=%h b=%h diff=%h lat=%0d", ai, bi, diff8, lat);
    endtask

    initial begin
        int done_cnt;
        int done_at[$];
        logic [4:0] exp5;

        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;

        // Reset held for two cycles, then idle with start low.
        tick();
        tick();
        check("rst busy",   16'(busy),   16'd0);
        check("rst done",   16'(done),   16'd0);
        check("rst diff",   16'(diff),   16'd0);
        check("rst borrow", 16'(borrow), 16'd0);
        check("rst diff8",  16'(diff8),  16'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle busy", 16'(busy), 16'd0);
        end

        run4("basic0", 4'b0001, 4'b0000, 5'b00001);
        run4("basic1", 4'b0000, 4'b0011, 5'b11101);
        run4("furth0", 4'b0101, 4'b1101, 5'b11000);
        run4("furth1", 4'b1000, 4'b1000, 5'b00000);
        run4("furth2", 4'b1111, 4'b0001, 5'b01110);

        // A second start pulse during RUN must be ignored.
        start = 1'b1;
        a     = 4'b0111;
        b     = 4'b0010;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        a     = 4'b1111;
        b     = 4'b0000;
        tick();
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                done_cnt++;
                check("midrun diff", 16'(diff), 16'b00101);
            end
            tick();
        end
        check("midrun done_count", 16'(done_cnt), 16'd1);
        $display("[TB] midrun start ignored, done pulses=%0d", done_cnt);

        // start held high: one result every 6 cycles.
        start = 1'b1;
        a     = 4'b0110;
        b     = 4'b0011;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (done) begin
                done_at.push_back(cyc);
                check("b2b diff", 16'(diff), 16'b00011);
            end
        end
        start = 1'b0;
        check("b2b count", 16'(done_at.size()), 16'd3);
        if (done_at.size() >= 3) begin
            check("b2b first",   16'(done_at[0]),              16'd4);
            check("b2b period1", 16'(done_at[1] - done_at[0]), 16'd6);
            check("b2b period2", 16'(done_at[2] - done_at[1]), 16'd6);
        end
        $display("[TB] back-to-back done pulses=%0d", done_at.size());
        for (int i = 0; i < 8; i++) tick();
        check("b2b settled", 16'(busy), 16'd0);

        // Reset sampled at E2 of a run aborts it without a done pulse.
        start = 1'b1;
        a     = 4'b1001;
        b     = 4'b0110;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy",   16'(busy),   16'd0);
        check("abort done",   16'(done),   16'd0);
        check("abort diff",   16'(diff),   16'd0);
        check("abort borrow", 16'(borrow), 16'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort no_done", 16'(done_cnt), 16'd0);
        $display("[TB] reset mid-run: busy=%b diff=%b", busy, diff);
        run4("after_abort", 4'b0011, 4'b0001, 5'b00010);

        // Full sweep of WIDTH = 4 against the modular reference.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                exp5 = {1'b0, 4'(ai)} - {1'b0, 4'(bi)};
                run4("sweep", 4'(ai), 4'(bi), exp5);
            end
        end

        // Random pairs at WIDTH = 8, plus the extremes.
        run8(8'hFF, 8'h00);
        run8(8'h00, 8'hFF);
        for (int i = 0; i < 30; i++) begin
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller. It computes A − B for WIDTH-bit unsigned operands by pushing one bit pair per cycle through a single 1-bit full-subtractor cell, LSB first, and chaining the borrow in a register. It gives the ALU a low-area alternative to the ripple subtractor, with a start/busy/done handshake for the sequencing logic above it.

## Interface
Parameters:
- WIDTH, default 4, operand width in bits (≥ 2).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; diff is valid while it is high.
- diff  output  WIDTH+1  result; bit WIDTH is the final borrow, so the value is the two's-complement A − B.
- borrow  output  1  equals diff[WIDTH]; high when A < B.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: one bit computed per cycle.
  - DONE: result presented for one cycle.
- IDLE → RUN when start = 1.
  - Load shift registers: sa ← a, sb ← b.
  - Clear the borrow flop and the bit counter.
- RUN, each cycle:
  - Cell inputs: sa[0], sb[0], borrow flop.
  - Cell difference bit is shifted into the result register at the MSB side of the low WIDTH bits.
  - Borrow flop ← cell borrow-out.
  - sa and sb shift right by 1.
  - Counter increments.
- RUN → DONE after the WIDTH-th bit.
  - diff[WIDTH-1:0] ← assembled result.
  - diff[WIDTH] ← final borrow.
  - done = 1.
- DONE → IDLE unconditionally. start is ignored in DONE.
- start is ignored while busy. a and b may change freely after the accepting edge.
- diff and borrow hold their value until the next DONE entry. They are not cleared on a new start.
- Cell equations:
  - d = x ⊕ y ⊕ bin
  - bout = (¬x·y) + (¬(x⊕y)·bin)
- Reset, in any state including mid-RUN:
  - State → IDLE.
  - busy, done, diff, borrow, counter, borrow flop and shift registers all → 0.
  - The partial result is discarded. No done pulse is produced for an aborted operation.
- If reset and start are high together, reset wins and the request is dropped.

## Timing
- Edge E0: start = 1 seen in IDLE; busy = 1 from E0.
- Edges E1 … E_WIDTH: bits 0 … WIDTH-1 computed.
- After E_WIDTH: state DONE, done = 1, diff valid.
- Edge E_WIDTH+1: IDLE, busy = 0, done = 0.
- Latency from the accepting edge to done high is WIDTH edges. busy stays high for WIDTH+1 cycles.
- Back-to-back: start held high is accepted again in the first IDLE cycle, giving one result every WIDTH+2 cycles.
- Counter width is $clog2(WIDTH+1). It never wraps, because RUN exits exactly at count WIDTH−1.
- All outputs are registered. There is no combinational path from start, a or b to any output.

## Structure
- Shared ALU package:
  - state encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2. Encoding 2'd3 is illegal and decodes to IDLE on the next edge.
  - default WIDTH constant.
- Sub-module sub_bit_cell: the 1-bit full subtractor.
  - Ports: bout, d, x, y, bin.
  - Gate-level, instantiated once.
- Top level holds the FSM, counter, shift registers, borrow flop and result register.

## Test plan
- Reset then idle: hold reset for 2 cycles. Expect busy = 0, done = 0, diff = 00000, borrow = 0. start = 0 keeps it idle.
- Basic cases, WIDTH = 4, each pair expected after exactly 4 edges:
  - a = 0001, b = 0000 → diff = 00001, borrow = 0.
  - a = 0000, b = 0011 → diff = 11101, borrow = 1.
- Further cases:
  - a = 0101, b = 1101 → diff = 11000, borrow = 1.
  - a = 1000, b = 1000 → diff = 00000, borrow = 0.
  - a = 1111, b = 0001 → diff = 01110.
- Handshake:
  - Pulse start with a = 0111, b = 0010.
  - Pulse start again mid-RUN with different operands. Expect it ignored: diff = 00101, one done pulse only.
  - Hold start high continuously. Expect done every 6 cycles.
- Reset mid-operation:
  - Assert reset at edge E2 of a run with a = 1001, b = 0110. Expect IDLE and all outputs 0 next cycle, and no done pulse.
  - Then start with a = 0011, b = 0001. Expect diff = 00010.
- Randomized sweep of all 256 (a, b) pairs for WIDTH = 4, checked against the reference model {1'b0, a} − {1'b0, b} mod 32. Repeat with WIDTH = 8 on random pairs.
